// File: rtl/asic_top.sv
// asic_top: pad ring around ip_1, a UART-fed 2x2 matrix engine.
// Results are shown on GPIO pads and echoed back over UART TX.
module asic_top #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic sys_clk_i_pad,
  input  logic rst_n_pad,
  output logic sys_clk_o_pad,
  input  logic ip_sel_pad0,
  input  logic ip_sel_pad1,
  input  logic ip_sel_pad2,
  inout  wire  io_pad0,  io_pad1,  io_pad2,  io_pad3,
  inout  wire  io_pad4,  io_pad5,  io_pad6,  io_pad7,
  inout  wire  io_pad8,  io_pad9,  io_pad10, io_pad11,
  inout  wire  io_pad12, io_pad13, io_pad14, io_pad15,
  inout  wire  io_pad16, io_pad17, io_pad18, io_pad19,
  inout  wire  io_pad20, io_pad21, io_pad22, io_pad23,
  inout  wire  io_pad24, io_pad25, io_pad26, io_pad27,
  inout  wire  io_pad28, io_pad29, io_pad30, io_pad31,
  inout  wire  io_pad32, io_pad33, io_pad34, io_pad35,
  inout  wire  io_pad36, io_pad37, io_pad38, io_pad39,
  inout  wire  io_pad40, io_pad41, io_pad42, io_pad43,
  inout  wire  io_pad44, io_pad45, io_pad46, io_pad47,
  inout  wire  io_pad48, io_pad49, io_pad50, io_pad51,
  inout  wire  io_pad52, io_pad53, io_pad54, io_pad55,
  inout  wire  io_pad56, io_pad57, io_pad58, io_pad59,
  inout  wire  io_pad60, io_pad61, io_pad62, io_pad63,
  inout  wire  io_pad64, io_pad65, io_pad66, io_pad67,
  inout  wire  io_pad68, io_pad69, io_pad70, io_pad71,
  inout  wire  io_pad72, io_pad73, io_pad74, io_pad75,
  inout  wire  io_pad76, io_pad77, io_pad78, io_pad79,
  inout  wire  io_pad80, io_pad81
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_e;

  logic clk, sel, clr;
  assign clk = sys_clk_i_pad;
  assign sys_clk_o_pad = sys_clk_i_pad;
  assign sel = ({ip_sel_pad2, ip_sel_pad1, ip_sel_pad0} == 3'b001);
  assign clr = !sel;

  logic rx_s1_q, rx_s2_q, rx_p_q;
  rx_st_e rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] m_q [4];
  logic [7:0] m_d [4];
  logic done_q, done_d;

  tx_st_e tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [1:0] tx_byte_q, tx_byte_d;
  logic [31:0] tx_w_q, tx_w_d;
  logic [31:0] gpio_q, gpio_d;
  logic pend_q, pend_d;
  logic [31:0] res;
  logic tx_line;

  always_ff @(posedge clk or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_p_q    <= 1'b1;
      rx_st_q   <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      idx_q     <= '0;
      m_q       <= '{default: 8'h00};
      done_q    <= 1'b0;
      tx_st_q   <= T_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
      tx_w_q    <= '0;
      gpio_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      rx_s1_q   <= clr | io_pad65;
      rx_s2_q   <= clr | rx_s1_q;
      rx_p_q    <= clr | rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      idx_q     <= idx_d;
      m_q       <= m_d;
      done_q    <= done_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
      tx_w_q    <= tx_w_d;
      gpio_q    <= gpio_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    idx_d    = idx_q;
    m_d      = m_q;
    done_d   = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_p_q && !rx_s2_q) rx_st_d = R_START;
      end
      R_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end
      R_STOP: if (rx_cnt_q == BIT_END) begin
        rx_st_d = R_IDLE;
        if (rx_s2_q) begin
          m_d[idx_q] = rx_sh_q;
          idx_d      = idx_q + 1'b1;
          done_d     = (idx_q == 2'd3);
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
    if (clr) begin
      rx_st_d  = R_IDLE;
      rx_cnt_d = '0;
      rx_bit_d = '0;
      rx_sh_d  = '0;
      idx_d    = '0;
      m_d      = '{default: 8'h00};
      done_d   = 1'b0;
    end
  end

  assign res = {m_q[3] + m_q[0], m_q[2] + m_q[1],
                m_q[1] + m_q[2], m_q[0] + m_q[3]};

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q + 1'b1;
    tx_bit_d  = tx_bit_q;
    tx_byte_d = tx_byte_q;
    tx_w_d    = tx_w_q;
    gpio_d    = gpio_q;
    pend_d    = pend_q;
    if (done_q) begin
      gpio_d = res;
      if (tx_st_q != T_IDLE) pend_d = 1'b1;
    end
    unique case (tx_st_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        if (done_q) begin
          tx_st_d   = T_START;
          tx_byte_d = '0;
          tx_w_d    = res;
        end
      end
      T_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d  = T_DATA;
      end
      T_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_st_d = T_STOP;
      end
      T_STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d  = '0;
        tx_byte_d = tx_byte_q + 1'b1;
        tx_st_d   = T_START;
        // after r3: chain straight into a queued result, else go idle
        if (tx_byte_q == 2'd3) begin
          if (done_q) begin
            tx_w_d = res;
            pend_d = 1'b0;
          end else if (pend_q) begin
            tx_w_d = gpio_q;
            pend_d = 1'b0;
          end else begin
            tx_st_d = T_IDLE;
          end
        end
      end
      default: tx_st_d = T_IDLE;
    endcase
    if (clr) begin
      tx_st_d   = T_IDLE;
      tx_cnt_d  = '0;
      tx_bit_d  = '0;
      tx_byte_d = '0;
      tx_w_d    = '0;
      gpio_d    = '0;
      pend_d    = 1'b0;
    end
  end

  assign tx_line = (tx_st_q == T_START) ? 1'b0 :
                   (tx_st_q == T_DATA)  ? tx_w_q[{tx_byte_q, tx_bit_q}] :
                   1'b1;

  assign io_pad64 = sel ? tx_line : 1'bz;

  assign io_pad0  = sel ? gpio_q[0]  : 1'bz,
         io_pad1  = sel ? gpio_q[1]  : 1'bz,
         io_pad2  = sel ? gpio_q[2]  : 1'bz,
         io_pad3  = sel ? gpio_q[3]  : 1'bz,
         io_pad4  = sel ? gpio_q[4]  : 1'bz,
         io_pad5  = sel ? gpio_q[5]  : 1'bz,
         io_pad6  = sel ? gpio_q[6]  : 1'bz,
         io_pad7  = sel ? gpio_q[7]  : 1'bz,
         io_pad8  = sel ? gpio_q[8]  : 1'bz,
         io_pad9  = sel ? gpio_q[9]  : 1'bz,
         io_pad10 = sel ? gpio_q[10] : 1'bz,
         io_pad11 = sel ? gpio_q[11] : 1'bz,
         io_pad12 = sel ? gpio_q[12] : 1'bz,
         io_pad13 = sel ? gpio_q[13] : 1'bz,
         io_pad14 = sel ? gpio_q[14] : 1'bz,
         io_pad15 = sel ? gpio_q[15] : 1'bz,
         io_pad16 = sel ? gpio_q[16] : 1'bz,
         io_pad17 = sel ? gpio_q[17] : 1'bz,
         io_pad18 = sel ? gpio_q[18] : 1'bz,
         io_pad19 = sel ? gpio_q[19] : 1'bz,
         io_pad20 = sel ? gpio_q[20] : 1'bz,
         io_pad21 = sel ? gpio_q[21] : 1'bz,
         io_pad22 = sel ? gpio_q[22] : 1'bz,
         io_pad23 = sel ? gpio_q[23] : 1'bz,
         io_pad24 = sel ? gpio_q[24] : 1'bz,
         io_pad25 = sel ? gpio_q[25] : 1'bz,
         io_pad26 = sel ? gpio_q[26] : 1'bz,
         io_pad27 = sel ? gpio_q[27] : 1'bz,
         io_pad28 = sel ? gpio_q[28] : 1'bz,
         io_pad29 = sel ? gpio_q[29] : 1'bz,
         io_pad30 = sel ? gpio_q[30] : 1'bz,
         io_pad31 = sel ? gpio_q[31] : 1'bz;

  assign io_pad32 = 1'bz, io_pad33 = 1'bz, io_pad34 = 1'bz,
         io_pad35 = 1'bz, io_pad36 = 1'bz, io_pad37 = 1'bz,
         io_pad38 = 1'bz, io_pad39 = 1'bz, io_pad40 = 1'bz,
         io_pad41 = 1'bz, io_pad42 = 1'bz, io_pad43 = 1'bz,
         io_pad44 = 1'bz, io_pad45 = 1'bz, io_pad46 = 1'bz,
         io_pad47 = 1'bz, io_pad48 = 1'bz, io_pad49 = 1'bz,
         io_pad50 = 1'bz, io_pad51 = 1'bz, io_pad52 = 1'bz,
         io_pad53 = 1'bz, io_pad54 = 1'bz, io_pad55 = 1'bz,
         io_pad56 = 1'bz, io_pad57 = 1'bz, io_pad58 = 1'bz,
         io_pad59 = 1'bz, io_pad60 = 1'bz, io_pad61 = 1'bz,
         io_pad62 = 1'bz, io_pad63 = 1'bz, io_pad66 = 1'bz,
         io_pad67 = 1'bz, io_pad68 = 1'bz, io_pad69 = 1'bz,
         io_pad70 = 1'bz, io_pad71 = 1'bz, io_pad72 = 1'bz,
         io_pad73 = 1'bz, io_pad74 = 1'bz, io_pad75 = 1'bz,
         io_pad76 = 1'bz, io_pad77 = 1'bz, io_pad78 = 1'bz,
         io_pad79 = 1'bz, io_pad80 = 1'bz, io_pad81 = 1'bz;

endmodule

// File: tb/tb_asic_top.sv
// tb_asic_top: directed UART frames into ip_1, checks GPIO pads
// and the echoed TX bytes against hand-computed matrix sums.
module tb_asic_top;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] sel = 3'b001;
  logic rx_drv = 1'b1;
  logic mon_en = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] txq [$];

  tri1 [31:0] gp;
  tri0 txp;
  wire rxp;
  wire [47:0] rsv;
  wire clk_o;

  assign rxp = rx_drv;
  always #5 clk = ~clk;

  asic_top #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk_i_pad(clk), .rst_n_pad(rst_n), .sys_clk_o_pad(clk_o),
    .ip_sel_pad0(sel[0]), .ip_sel_pad1(sel[1]), .ip_sel_pad2(sel[2]),
    .io_pad0(gp[0]),   .io_pad1(gp[1]),   .io_pad2(gp[2]),   .io_pad3(gp[3]),
    .io_pad4(gp[4]),   .io_pad5(gp[5]),   .io_pad6(gp[6]),   .io_pad7(gp[7]),
    .io_pad8(gp[8]),   .io_pad9(gp[9]),   .io_pad10(gp[10]), .io_pad11(gp[11]),
    .io_pad12(gp[12]), .io_pad13(gp[13]), .io_pad14(gp[14]), .io_pad15(gp[15]),
    .io_pad16(gp[16]), .io_pad17(gp[17]), .io_pad18(gp[18]), .io_pad19(gp[19]),
    .io_pad20(gp[20]), .io_pad21(gp[21]), .io_pad22(gp[22]), .io_pad23(gp[23]),
    .io_pad24(gp[24]), .io_pad25(gp[25]), .io_pad26(gp[26]), .io_pad27(gp[27]),
    .io_pad28(gp[28]), .io_pad29(gp[29]), .io_pad30(gp[30]), .io_pad31(gp[31]),
    .io_pad32(rsv[0]),  .io_pad33(rsv[1]),  .io_pad34(rsv[2]),  .io_pad35(rsv[3]),
    .io_pad36(rsv[4]),  .io_pad37(rsv[5]),  .io_pad38(rsv[6]),  .io_pad39(rsv[7]),
    .io_pad40(rsv[8]),  .io_pad41(rsv[9]),  .io_pad42(rsv[10]), .io_pad43(rsv[11]),
    .io_pad44(rsv[12]), .io_pad45(rsv[13]), .io_pad46(rsv[14]), .io_pad47(rsv[15]),
    .io_pad48(rsv[16]), .io_pad49(rsv[17]), .io_pad50(rsv[18]), .io_pad51(rsv[19]),
    .io_pad52(rsv[20]), .io_pad53(rsv[21]), .io_pad54(rsv[22]), .io_pad55(rsv[23]),
    .io_pad56(rsv[24]), .io_pad57(rsv[25]), .io_pad58(rsv[26]), .io_pad59(rsv[27]),
    .io_pad60(rsv[28]), .io_pad61(rsv[29]), .io_pad62(rsv[30]), .io_pad63(rsv[31]),
    .io_pad64(txp),     .io_pad65(rxp),
    .io_pad66(rsv[32]), .io_pad67(rsv[33]), .io_pad68(rsv[34]), .io_pad69(rsv[35]),
    .io_pad70(rsv[36]), .io_pad71(rsv[37]), .io_pad72(rsv[38]), .io_pad73(rsv[39]),
    .io_pad74(rsv[40]), .io_pad75(rsv[41]), .io_pad76(rsv[42]), .io_pad77(rsv[43]),
    .io_pad78(rsv[44]), .io_pad79(rsv[45]), .io_pad80(rsv[46]), .io_pad81(rsv[47])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_ok;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_mat(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (txq.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (txq.size() < n) check("tx_timeout", txq.size(), n);
  endtask

  task automatic chk_tx(input logic [31:0] w);
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      got = 32'hx;
      if (txq.size() > 0) got = {24'h0, txq.pop_front()};
      check($sformatf("tx_byte%0d", i), got, {24'h0, w[8*i +: 8]});
    end
  endtask

  // TX line monitor: samples each bit at its centre
  initial begin
    logic tx_prev;
    logic [7:0] b;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && tx_prev && !txp) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txp;
        end
        repeat (CPB) @(negedge clk);
        if (txp) txq.push_back(b);
      end
      tx_prev = txp;
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_gpio", gp, 32'h0);
    check("rst_tx", {31'h0, txp}, 32'h1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    send_mat(32'h04030201);
    repeat (4) @(negedge clk);
    check("m1_gpio", gp, 32'h05050505);
    wait_tx(4);
    chk_tx(32'h05050505);

    send_mat(32'h022010FF);
    repeat (4) @(negedge clk);
    check("m2_gpio", gp, 32'h01303001);
    wait_tx(4);
    chk_tx(32'h01303001);

    send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (4) @(negedge clk);
    check("frm_hold", gp, 32'h01303001);
    send_byte(8'h48, 1'b1);
    repeat (4) @(negedge clk);
    check("frm_gpio", gp, 32'h59565659);
    wait_tx(4);
    chk_tx(32'h59565659);

    send_mat(32'h01010101);
    send_mat(32'h41302010);
    repeat (2) @(negedge clk);
    check("ovl_gpio", gp, 32'h51505051);
    check("ovl_busy", txq.size(), 3);
    wait_tx(8);
    chk_tx(32'h02020202);
    chk_tx(32'h51505051);

    send_byte(8'h09, 1'b1);
    send_byte(8'h09, 1'b1);
    mon_en = 1'b0;
    @(negedge clk);
    sel = 3'b000;
    #1;
    check("desel_gpio", gp, 32'hFFFFFFFF);
    check("desel_tx", {31'h0, txp}, 32'h0);
    send_byte(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    check("desel_hold", gp, 32'hFFFFFFFF);
    sel = 3'b001;
    repeat (2) @(negedge clk);
    check("resel_gpio", gp, 32'h0);
    mon_en = 1'b1;
    send_mat(32'h08040201);
    repeat (4) @(negedge clk);
    check("resel_mat", gp, 32'h09060609);

    repeat (100) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'h0, txp}, 32'h1);
    check("rst_mid_gpio", gp, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    txq.delete();
    mon_en = 1'b1;

    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_gpio", gp, 32'h0);
    send_mat(32'h0B070503);
    repeat (4) @(negedge clk);
    check("glitch_mat", gp, 32'h0E0C0C0E);
    wait_tx(4);
    chk_tx(32'h0E0C0C0E);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/asic_top.md
ASIC_TOP -- requirements
Module: asic_top

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning sys_clk cycles per UART bit (115200 baud at 100 MHz).
REQ-002 sys_clk_i_pad  input  1  sole system clock; all logic on rising edge.
REQ-003 rst_n_pad  input  1  reset, asynchronous, active-low.
REQ-004 sys_clk_o_pad  output  1  clock echo, equal to sys_clk_i_pad combinationally.
REQ-005 ip_sel_pad0..ip_sel_pad2  input  1 each  IP select code {pad2,pad1,pad0}; 3'b001 selects ip_1.
REQ-006 io_pad0..io_pad31  inout  1 each  result GPIO; io_padN carries result word bit N.
REQ-007 io_pad64  inout  1  ip_1 UART TX output.
REQ-008 io_pad65  inout  1  ip_1 UART RX input; never driven by asic_top.
REQ-009 io_pad32..io_pad63, io_pad66..io_pad81  inout  1 each  reserved; always high-Z.

Function
REQ-010 ip_1 = UART-fed 2x2 matrix engine: receive 4 bytes m0..m3, compute result bytes, present them on GPIO and send them back on UART TX.
REQ-011 Select 3'b001: engine runs; io_pad0..31 and io_pad64 driven.
REQ-012 Any other select code: io_pad0..31 and io_pad64 high-Z; engine held in synchronous reset (all state to reset values) while deselected.
REQ-013 Select changes take effect on pad enables combinationally; engine reset state applies from the next clock edge.
REQ-014 RX: io_pad65 passes a 2-flop synchronizer before use.
REQ-015 RX frame 8N1, LSB first: on a 1->0 transition while idle, wait CLKS_PER_BIT/2 cycles; if line is still low, sample 8 data bits at CLKS_PER_BIT intervals, then sample the stop bit one interval later.
REQ-016 Start bit high at mid-sample: frame abandoned, back to idle, no byte.
REQ-017 Stop bit 0: byte discarded, byte index unchanged.
REQ-018 Valid byte: stored at m[idx]; idx increments 0..3.
REQ-019 On the 4th valid byte, idx wraps to 0 and the result is computed the next cycle: r0=m0+m3, r1=m1+m2, r2=m2+m1, r3=m3+m0, each sum modulo 256.
REQ-020 The result word {r3,r2,r1,r0} latches into the GPIO register in that same cycle and holds until the next completed matrix.
REQ-021 TX: after a result latches, send r0, r1, r2, r3 back-to-back, 8N1, LSB first, each bit CLKS_PER_BIT cycles; line high when idle.
REQ-022 TX state machine: IDLE -> START -> DATA(8 bits) -> STOP -> next byte or IDLE after r3.
REQ-023 RX operates independently during TX; bytes received during TX fill the next matrix.
REQ-024 A matrix completing while TX is busy updates GPIO immediately and sets a single pending flag; the 4-byte send of the then-current result starts when the current send finishes.
REQ-025 Further completions while pending only refresh the result; at most one queued send.
REQ-026 A select change or reset mid-frame aborts RX/TX immediately; a partial matrix is lost.

Reset
REQ-027 While rst_n_pad is low, or in any deselected state: idx=0, m0..m3=0, GPIO register=0, pending=0, RX and TX idle, TX line high.
REQ-028 While rst_n_pad is low with ip_1 selected, io_pad0..31 drive 0 and io_pad64 drives 1.
REQ-029 After rst_n_pad rises, the first valid start edge is accepted on the first clock edge.

Verification
REQ-030 ip_sel=001, send bytes 0x01,0x02,0x03,0x04 spaced 150 us -> GPIO=0x05050505 after 4th stop bit; TX emits 0x05,0x05,0x05,0x05.
REQ-031 Send 0xFF,0x10,0x20,0x02 -> r0=0x01 (wrap), r1=r2=0x30, r3=0x01; GPIO=0x01303001.
REQ-032 Frame with stop bit 0 between valid bytes -> discarded; the next 4 valid bytes still form the matrix.
REQ-033 Send a second 4-byte matrix while the first result is transmitting -> GPIO updates on 4th byte; second 4-byte TX follows the first with no gap beyond one idle bit.
REQ-034 ip_sel=000 -> io_pad0..31 and io_pad64 high-Z; RX bytes are ignored; returning to 001 starts with idx=0.
REQ-035 Assert rst_n_pad mid-TX -> io_pad64 high and GPIO 0 at once; 1-cycle low start glitch on RX -> rejected.
